dram_write_arbiter: RTL and testbench
=====================================

Name: dram_write_arbiter

Overview:
- Owns the single write port of a 32x16 distributed RAM: write address (ADDRH), eight 2-bit data lanes (DIA..DIH) and WE.
- Clears the RAM after reset or on request, then shares the write port between NREQ requesters using round-robin arbitration.
- Read ports A..G are driven elsewhere. Port H reads at ram_waddr.

Parameters:
- NREQ, 4: number of write requesters (2..8).
- CLEAR_VAL, 16'h0000: word written to every address during a clear sequence.

Ports:
- clk  in  1  write clock, same net as the RAM WCLK.
- rst_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  level request to re-run the clear sequence.
- req  in  NREQ  per-requester write request.
- req_addr  in  NREQ*5  requester i address at bits [5i+4:5i].
- req_data  in  NREQ*16  requester i data at bits [16i+15:16i].
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- ready  out  1  high in RUN state.
- busy  out  1  high in CLEAR state.
- ram_waddr  out  5  drives ADDRH.
- ram_wdata  out  16  bits [2k+1:2k] drive lane k (k=0 is A, k=7 is H).
- ram_we  out  1  drives WE.

Behaviour:
- Reset (rst_n=0, async):
  - gnt=0, ram_we=0, ram_waddr=0, ram_wdata=0, ready=0, busy=1.
  - state=CLEAR, clear counter=0, round-robin pointer=0.
  - ram_we stays low for the whole reset, so no write occurs.
  - Reset asserted in the middle of a clear or a grant aborts it. After release the block restarts a full clear from address 0.
- All outputs are registered.
- CLEAR state:
  - On each clock edge: ram_we=1, ram_waddr=cnt, ram_wdata=CLEAR_VAL, cnt++. The RAM captures the write on the following edge.
  - Exactly 32 consecutive ram_we cycles, addresses 0..31 in order.
  - On the edge that issues address 31, the next state is RUN.
  - busy=1, ready=0, gnt=0 throughout. req and clear_req are ignored.
- RUN state, arbitration on each edge:
  - Eligible requesters: i with req[i]=1 and gnt[i]=0. The currently granted requester is masked for one edge so a requester that is still holding req is not re-granted.
  - Search starts at pointer and runs upward modulo NREQ. The first eligible i wins.
  - For the winner: gnt[i]=1, ram_we=1, ram_waddr=req_addr[i], ram_wdata=req_data[i], pointer=(i+1) mod NREQ.
  - With no eligible requester: gnt=0 and ram_we=0. ram_waddr and ram_wdata hold their values. The pointer is unchanged.
  - Grant latency is 1 cycle from the first sampled req. The RAM write lands on the edge ending the gnt cycle.
  - Requesters hold req, addr and data until they see gnt. They may drop req in the gnt cycle.
  - Throughput is one write per cycle across requesters. A single requester gets at most one write every 2 cycles.
- clear_req in RUN:
  - Sampled high, it overrides arbitration: no grant on that edge, next state=CLEAR, cnt=0, ready=0, busy=1.
  - A write already registered (ram_we=1) still completes.
  - Pending requests stay pending and are served after the clear, with the pointer preserved.
- Width rules:
  - Address is 5 bits and wraps naturally.
  - The clear counter is 5 bits. The end of a clear is detected at cnt==31, not by overflow.

Test Plan:
- Reset release with all req=0 → ram_we high for exactly 32 cycles, ram_waddr 0,1,...,31, ram_wdata=16'h0000. ready rises on the cycle after the address-31 write. Read ports then return 0 at every address.
- RUN, req=4'b0001, addr 5'd7, data 16'hA5C3 → gnt=4'b0001 one cycle later for one cycle. RAM address 7 then reads 2'b11 on lane A (DOA), 2'b10 on lane H (DOH), per the lane mapping.
- RUN, req=4'b1111 held continuously with distinct addresses → grant order 0,1,2,3,0,1,... with one gnt per cycle and no requester granted on two consecutive cycles.
- req[2] alone held for 4 cycles → gnt[2] pulses in alternate cycles only, never on consecutive edges.
- clear_req pulsed together with req=4'b0010 → no grant, busy=1 for 32 cycles. After ready, gnt[1] is issued and its write lands on the cleared RAM.
- rst_n dropped while the clear is at cnt=12 → all outputs go to reset values immediately. After release a full 0..31 clear restarts.

Source files
------------

// File: rtl/dram_write_arbiter.sv
// dram_write_arbiter
//   Owns the single write port of a 32x16 distributed RAM. After reset, or when
//   clear_req is sampled high in RUN, it writes CLEAR_VAL to addresses 0..31.
//   It then shares the write port between NREQ requesters using round-robin
//   arbitration. All outputs are registered.
//
// Ports
//   clk        write clock (same net as RAM WCLK)
//   rst_n      asynchronous active-low reset
//   clear_req  level request to re-run the clear sequence
//   req        per-requester write request
//   req_addr   requester i address at [5i+4:5i]
//   req_data   requester i data at [16i+15:16i]
//   gnt        one-hot, one-cycle grant pulse
//   ready      high in RUN
//   busy       high in CLEAR
//   ram_waddr  RAM ADDRH
//   ram_wdata  RAM lanes; bits [2k+1:2k] drive lane k (A..H)
//   ram_we     RAM WE
module dram_write_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter logic [15:0] CLEAR_VAL = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_req,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*5-1:0]  req_addr,
  input  logic [NREQ*16-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               ready,
  output logic               busy,
  output logic [4:0]         ram_waddr,
  output logic [15:0]        ram_wdata,
  output logic               ram_we
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            ready_q, busy_q;

  logic [4:0]      addr_arr [NREQ];
  logic [15:0]     data_arr [NREQ];
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[5*i +: 5];
    assign data_arr[i] = req_data[16*i +: 16];
  end

  // The requester granted last edge is masked so a held req is not re-granted.
  assign elig = req & ~gnt_q;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StClear: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = CLEAR_VAL;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StRun;
      end
      StRun: begin
        if (clear_req) begin
          // Pending requests stay pending; pointer is kept across the clear.
          state_d = StClear;
          cnt_d   = '0;
        end else if (found) begin
          gnt_d[win] = 1'b1;
          we_d       = 1'b1;
          waddr_d    = addr_arr[win];
          wdata_d    = data_arr[win];
          ptr_d      = PtrW'((32'(win) + 1) % NREQ);
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == StRun);
      busy_q  <= (state_d == StClear);
    end
  end

  assign gnt       = gnt_q;
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dram_write_arbiter.sv
// Self-checking bench for dram_write_arbiter (NREQ=4, CLEAR_VAL=0).
// Grant sequences come from a vector table; granted writes are checked by a
// scoreboard queue; a behavioural RAM checks what actually lands.
module tb_dram_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        ready, busy;
  logic [4:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        ram_we;

  dram_write_arbiter #(.NREQ(4), .CLEAR_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .ready     (ready),
    .busy      (busy),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t sb_e;
  logic [15:0] mem [32];

  // Behavioural RAM; filled with a non-zero pattern while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 32; a++) mem[a] <= 16'hFFFF;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Scoreboard: every granted write must match the next expected entry.
  always @(posedge clk) begin
    if (rst_n && ram_we && gnt != 4'b0000) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got gnt=%b addr=%0d data=%h, required no write",
                 gnt, ram_waddr, ram_wdata);
      end else begin
        sb_e = sbq.pop_front();
        if ({gnt, ram_waddr, ram_wdata} !== sb_e) begin
          n_err++;
          $display("FAIL sb_write: got gnt=%b addr=%0d data=%h, required gnt=%b addr=%0d data=%h",
                   gnt, ram_waddr, ram_wdata, sb_e.gnt, sb_e.addr, sb_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 32'h0);
    chk({tag, "_we"},    32'(ram_we), 32'h0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 32'h0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'h0);
    chk({tag, "_ready"}, 32'(ready), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h1);
  endtask

  // 32 clear writes, one per edge, addresses 0..31.
  task automatic clear_seq();
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (ram_we !== 1'b1 || ram_waddr !== 5'(i) || ram_wdata !== 16'h0000 ||
          gnt !== 4'b0000 || (i < 31 && busy !== 1'b1)) begin
        bad++;
        $display("FAIL clear_step%0d: got we=%b addr=%0d data=%h gnt=%b busy=%b, required we=1 addr=%0d data=0000 gnt=0000 busy=1",
                 i, ram_we, ram_waddr, ram_wdata, gnt, busy, i);
      end
    end
    n_vec++;
    if (bad != 0) n_err++;
  endtask

  task automatic chk_mem_zero(input string name);
    int nz = 0;
    for (int a = 0; a < 32; a++) if (mem[a] !== 16'h0000) nz++;
    chk(name, 32'(nz), 32'h0);
  endtask

  vec_t        tbl [15];
  logic [4:0]  prev_addr;
  logic [15:0] prev_data;
  int          w;

  initial begin
    tbl[0]  = '{4'b1111, 4'b0010};
    tbl[1]  = '{4'b1111, 4'b0100};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0010};
    tbl[5]  = '{4'b0100, 4'b0100};
    tbl[6]  = '{4'b0100, 4'b0000};
    tbl[7]  = '{4'b0100, 4'b0100};
    tbl[8]  = '{4'b0100, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b1001, 4'b0001};
    tbl[12] = '{4'b1010, 4'b0010};
    tbl[13] = '{4'b0011, 4'b0001};
    tbl[14] = '{4'b0000, 4'b0000};

    rst_n = 1'b0; clear_req = 1'b0; req = '0; req_addr = '0; req_data = '0;
    repeat (3) tick();
    chk_reset_vals("reset");

    // Clear after reset release.
    rst_n = 1'b1;
    clear_seq();
    tick();
    chk("post_clear_ready", 32'(ready), 32'h1);
    chk("post_clear_busy", 32'(busy), 32'h0);
    chk("post_clear_we", 32'(ram_we), 32'h0);
    chk_mem_zero("post_clear_mem");

    // Single request, checks lane mapping.
    req = 4'b0001; req_addr[4:0] = 5'd7; req_data[15:0] = 16'hA5C3;
    sbq.push_back({4'b0001, 5'd7, 16'hA5C3});
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_we", 32'(ram_we), 32'h1);
    req = '0;
    tick();
    chk("single_gnt_off", 32'(gnt), 32'h0);
    chk("single_we_off", 32'(ram_we), 32'h0);
    chk("lane_a", 32'(mem[7][1:0]), 32'h3);
    chk("lane_h", 32'(mem[7][15:14]), 32'h2);
    prev_addr = 5'd7;
    prev_data = 16'hA5C3;

    // Table-driven arbitration vectors.
    for (int r = 0; r < 15; r++) begin
      req = tbl[r].req;
      for (int i = 0; i < 4; i++) begin
        req_addr[5*i +: 5]   = 5'(16 + 3 * i);
        req_data[16*i +: 16] = 16'(16'h1111 * (i + 1)) ^ 16'(r);
      end
      if (tbl[r].gnt != 4'b0000) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (tbl[r].gnt[i]) w = i;
        sbq.push_back({tbl[r].gnt, 5'(16 + 3 * w), 16'(16'h1111 * (w + 1)) ^ 16'(r)});
      end
      tick();
      chk($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      chk($sformatf("vec%0d_we", r), 32'(ram_we), 32'(tbl[r].gnt != 4'b0000));
      if (tbl[r].gnt != 4'b0000) begin
        prev_addr = 5'(16 + 3 * w);
        prev_data = 16'(16'h1111 * (w + 1)) ^ 16'(r);
      end else begin
        chk($sformatf("vec%0d_hold", r), {11'h0, ram_waddr, ram_wdata}, {11'h0, prev_addr, prev_data});
      end
    end
    req = '0;
    tick();

    // clear_req together with a request: request waits out the clear.
    clear_req = 1'b1; req = 4'b0010; req_addr[9:5] = 5'd3; req_data[31:16] = 16'hBEEF;
    tick();
    clear_req = 1'b0;
    chk("clrreq_gnt", 32'(gnt), 32'h0);
    chk("clrreq_we", 32'(ram_we), 32'h0);
    chk("clrreq_busy", 32'(busy), 32'h1);
    chk("clrreq_ready", 32'(ready), 32'h0);
    sbq.push_back({4'b0010, 5'd3, 16'hBEEF});
    clear_seq();
    tick();
    chk("clrreq_after_gnt", 32'(gnt), 32'h2);
    chk("clrreq_after_ready", 32'(ready), 32'h1);
    req = '0;
    tick();
    chk("clrreq_mem3", 32'(mem[3]), 32'hBEEF);
    chk("clrreq_mem0", 32'(mem[0]), 32'h0);

    // Reset in the middle of a clear restarts from address 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (12) tick();
    chk("midclr_addr", 32'(ram_waddr), 32'd11);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midclr_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    clear_seq();
    tick();
    chk("midclr_ready", 32'(ready), 32'h1);
    chk_mem_zero("midclr_mem");

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
